// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings for the data-memory arbiter
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      DRAIN = 2'd1,
      LOCK  = 2'd2
   } arb_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug data-memory arbiter with debug lock
// Optional DMEM_ARB_ROUND_ROBIN_EN: alternate simultaneous requests instead of CPU-first.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_cpu_req,
   input  logic                  i_cpu_wen,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [31:0]           i_cpu_din,
   input  logic [1:0]            i_cpu_size,
   input  logic                  i_dbg_req,
   input  logic                  i_dbg_wen,
   input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
   input  logic [31:0]           i_dbg_din,
   input  logic [1:0]            i_dbg_size,
   input  logic                  i_dbg_lock,
   output logic                  o_cpu_gnt,
   output logic                  o_dbg_gnt,
   output logic                  o_cpu_rvalid,
   output logic                  o_dbg_rvalid,
   output logic [31:0]           o_cpu_rdata,
   output logic [31:0]           o_dbg_rdata,
   output logic                  o_locked,
   output logic                  o_mem_wen,
   output logic                  o_mem_ren,
   output logic [ADDR_WIDTH-1:0] o_mem_waddr,
   output logic [ADDR_WIDTH-1:0] o_mem_raddr,
   output logic [31:0]           o_mem_din,
   output logic [1:0]            o_mem_size,
   input  logic [31:0]           i_mem_dout
);

   arb_state_e state_q;
   logic       locked_q;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_owner_q, rd_owner_d;
   logic       cpu_gnt, dbg_gnt, any_gnt, sel_wen;
   logic       dbg_first;
   logic       cpu_rvalid, dbg_rvalid;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic prefer_dbg_q;

   assign dbg_first = prefer_dbg_q;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         prefer_dbg_q <= 1'b0;
      end else if (cpu_gnt) begin
         prefer_dbg_q <= 1'b1;
      end else if (dbg_gnt) begin
         prefer_dbg_q <= 1'b0;
      end
   end
`else
   assign dbg_first = 1'b0;
`endif

   // Grants are withheld during reset and in the cycle ARB sees the lock request.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!i_rst) begin
         case (state_q)
            ARB: begin
               if (!i_dbg_lock) begin
                  if (i_dbg_req && (dbg_first || !i_cpu_req)) begin
                     dbg_gnt = 1'b1;
                  end else begin
                     cpu_gnt = i_cpu_req;
                  end
               end
            end
            LOCK:    dbg_gnt = i_dbg_req;
            default: ;
         endcase
      end
   end

   assign any_gnt = cpu_gnt | dbg_gnt;
   assign sel_wen = dbg_gnt ? i_dbg_wen : i_cpu_wen;

   always_comb begin
      o_mem_wen   = 1'b0;
      o_mem_ren   = 1'b0;
      o_mem_waddr = '0;
      o_mem_raddr = '0;
      o_mem_din   = '0;
      o_mem_size  = '0;
      if (any_gnt) begin
         o_mem_wen   = sel_wen;
         o_mem_ren   = ~sel_wen;
         o_mem_waddr = dbg_gnt ? i_dbg_addr : i_cpu_addr;
         o_mem_raddr = dbg_gnt ? i_dbg_addr : i_cpu_addr;
         o_mem_din   = dbg_gnt ? i_dbg_din  : i_cpu_din;
         o_mem_size  = dbg_gnt ? i_dbg_size : i_cpu_size;
      end
   end

   assign rd_pend_d  = any_gnt & ~sel_wen;
   assign rd_owner_d = dbg_gnt ? OWNER_DBG : OWNER_CPU;

   // An outstanding read is answered in the ARB exit cycle itself, so DRAIN lasts one cycle.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q    <= ARB;
         locked_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWNER_CPU;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         case (state_q)
            ARB: begin
               if (i_dbg_lock) begin
                  state_q  <= rd_pend_q ? DRAIN : LOCK;
                  locked_q <= ~rd_pend_q;
               end
            end
            DRAIN: begin
               state_q  <= LOCK;
               locked_q <= 1'b1;
            end
            LOCK: begin
               if (!i_dbg_lock) begin
                  state_q  <= ARB;
                  locked_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ARB;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   // Reset kills a response that is due in the same cycle.
   assign cpu_rvalid = rd_pend_q & (rd_owner_q == OWNER_CPU) & ~i_rst;
   assign dbg_rvalid = rd_pend_q & (rd_owner_q == OWNER_DBG) & ~i_rst;

   assign o_cpu_gnt    = cpu_gnt;
   assign o_dbg_gnt    = dbg_gnt;
   assign o_cpu_rvalid = cpu_rvalid;
   assign o_dbg_rvalid = dbg_rvalid;
   assign o_cpu_rdata  = cpu_rvalid ? i_mem_dout : 32'd0;
   assign o_dbg_rdata  = dbg_rvalid ? i_mem_dout : 32'd0;
   assign o_locked     = locked_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 5;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic        vld;
      logic        own;
      logic [31:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_cpu_req, i_cpu_wen, i_dbg_req, i_dbg_wen, i_dbg_lock;
   logic [AW-1:0] i_cpu_addr, i_dbg_addr;
   logic [31:0]   i_cpu_din, i_dbg_din;
   logic [1:0]    i_cpu_size, i_dbg_size;
   logic          o_cpu_gnt, o_dbg_gnt, o_cpu_rvalid, o_dbg_rvalid, o_locked;
   logic [31:0]   o_cpu_rdata, o_dbg_rdata;
   logic          o_mem_wen, o_mem_ren;
   logic [AW-1:0] o_mem_waddr, o_mem_raddr;
   logic [31:0]   o_mem_din, i_mem_dout;
   logic [1:0]    o_mem_size;
   logic [31:0]   dout_q;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic pref_dbg = 1'b0;
   logic edg;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .i_rst(i_rst),
      .i_cpu_req(i_cpu_req), .i_dbg_req(i_dbg_req),
      .i_cpu_wen(i_cpu_wen), .i_dbg_wen(i_dbg_wen),
      .i_cpu_addr(i_cpu_addr), .i_dbg_addr(i_dbg_addr),
      .i_cpu_din(i_cpu_din), .i_dbg_din(i_dbg_din),
      .i_cpu_size(i_cpu_size), .i_dbg_size(i_dbg_size),
      .i_dbg_lock(i_dbg_lock),
      .o_cpu_gnt(o_cpu_gnt), .o_dbg_gnt(o_dbg_gnt),
      .o_cpu_rvalid(o_cpu_rvalid), .o_dbg_rvalid(o_dbg_rvalid),
      .o_cpu_rdata(o_cpu_rdata), .o_dbg_rdata(o_dbg_rdata),
      .o_locked(o_locked),
      .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
      .o_mem_waddr(o_mem_waddr), .o_mem_raddr(o_mem_raddr),
      .o_mem_din(o_mem_din), .o_mem_size(o_mem_size),
      .i_mem_dout(i_mem_dout)
   );

   function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
      return (a[4:2] == 3'd1) ? 32'h11223344 : (32'hC0DE0000 | 32'(a));
   endfunction

   always @(posedge clk) begin
      if (o_mem_ren) dout_q <= mem_fn(o_mem_raddr);
   end
   assign i_mem_dout = dout_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: check responses due now, grants, lock flag and memory port, then queue this cycle's read.
   task automatic cyc(input string tag, input logic e_cg, input logic e_dg, input logic e_lock);
      exp_t          r, e;
      logic          ew;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      logic [1:0]    es;
      @(negedge clk);
      r.vld = 1'b0; r.own = 1'b0; r.data = 32'd0;
      if (i_rst) sb.delete();
      else if (sb.size() > 0) r = sb.pop_front();
      chk({tag, ".cpu_rvalid"}, 32'(o_cpu_rvalid), 32'(r.vld && !r.own));
      chk({tag, ".dbg_rvalid"}, 32'(o_dbg_rvalid), 32'(r.vld && r.own));
      chk({tag, ".cpu_rdata"}, o_cpu_rdata, (r.vld && !r.own) ? r.data : 32'd0);
      chk({tag, ".dbg_rdata"}, o_dbg_rdata, (r.vld && r.own) ? r.data : 32'd0);
      chk({tag, ".cpu_gnt"}, 32'(o_cpu_gnt), 32'(e_cg));
      chk({tag, ".dbg_gnt"}, 32'(o_dbg_gnt), 32'(e_dg));
      chk({tag, ".locked"}, 32'(o_locked), 32'(e_lock));
      ew = 1'b0; ea = '0; ed = 32'd0; es = 2'd0;
      if (e_dg) begin
         ew = i_dbg_wen; ea = i_dbg_addr; ed = i_dbg_din; es = i_dbg_size;
      end else if (e_cg) begin
         ew = i_cpu_wen; ea = i_cpu_addr; ed = i_cpu_din; es = i_cpu_size;
      end
      chk({tag, ".mem_wen"}, 32'(o_mem_wen), 32'((e_cg || e_dg) && ew));
      chk({tag, ".mem_ren"}, 32'(o_mem_ren), 32'((e_cg || e_dg) && !ew));
      chk({tag, ".mem_waddr"}, 32'(o_mem_waddr), 32'(ea));
      chk({tag, ".mem_raddr"}, 32'(o_mem_raddr), 32'(ea));
      chk({tag, ".mem_din"}, o_mem_din, ed);
      chk({tag, ".mem_size"}, 32'(o_mem_size), 32'(es));
      if (i_rst) begin
         pref_dbg = 1'b0;
      end else begin
         e.vld = (e_cg || e_dg) && !ew;
         e.own = e_dg;
         e.data = mem_fn(ea);
         sb.push_back(e);
         if (e_cg) pref_dbg = 1'b1;
         if (e_dg) pref_dbg = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      i_rst = 1'b1;
      i_cpu_req = 1'b0; i_cpu_wen = 1'b0; i_cpu_addr = '0; i_cpu_din = 32'd0; i_cpu_size = SIZE_WORD;
      i_dbg_req = 1'b0; i_dbg_wen = 1'b0; i_dbg_addr = '0; i_dbg_din = 32'd0; i_dbg_size = SIZE_WORD;
      i_dbg_lock = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc("reset", 1'b0, 1'b0, 1'b0);
      i_rst = 1'b0;
      cyc("idle", 1'b0, 1'b0, 1'b0);

      // Single CPU word read of 0x04.
      i_cpu_req = 1'b1; i_cpu_addr = 5'h04;
      cyc("cpu_rd", 1'b1, 1'b0, 1'b0);
      i_cpu_req = 1'b0;
      cyc("cpu_rsp", 1'b0, 1'b0, 1'b0);

      // Both requesters read every cycle.
      i_cpu_req = 1'b1; i_cpu_addr = 5'h0C; i_cpu_size = SIZE_HALF;
      i_dbg_req = 1'b1; i_dbg_addr = 5'h10; i_dbg_size = SIZE_BYTE;
      for (int k = 0; k < 6; k++) begin
         edg = RR ? pref_dbg : 1'b0;
         cyc("both_rd", !edg, edg, 1'b0);
      end
      i_cpu_req = 1'b0; i_dbg_req = 1'b0; i_cpu_size = SIZE_WORD; i_dbg_size = SIZE_WORD;
      cyc("both_tail", 1'b0, 1'b0, 1'b0);

      // Lock raised behind an outstanding CPU read: DRAIN then LOCK.
      i_cpu_req = 1'b1; i_cpu_addr = 5'h14;
      cyc("drain_rd", 1'b1, 1'b0, 1'b0);
      i_cpu_addr = 5'h18; i_dbg_lock = 1'b1;
      cyc("drain_entry", 1'b0, 1'b0, 1'b0);
      cyc("drain", 1'b0, 1'b0, 1'b0);
      i_dbg_req = 1'b1; i_dbg_wen = 1'b1; i_dbg_addr = 5'h08; i_dbg_din = 32'hDEADBEEF;
      cyc("lock_wr", 1'b0, 1'b1, 1'b1);
      i_dbg_req = 1'b0; i_dbg_wen = 1'b0; i_dbg_lock = 1'b0;
      cyc("unlock", 1'b0, 1'b0, 1'b1);
      cyc("post_lock_cpu", 1'b1, 1'b0, 1'b0);
      i_cpu_req = 1'b0;
      cyc("post_lock_rsp", 1'b0, 1'b0, 1'b0);

      // Lock with nothing outstanding goes straight to LOCK; debug read inside lock.
      i_dbg_lock = 1'b1;
      cyc("lock_direct", 1'b0, 1'b0, 1'b0);
      i_dbg_req = 1'b1; i_dbg_addr = 5'h04; i_cpu_req = 1'b1;
      cyc("lock_dbg_rd", 1'b0, 1'b1, 1'b1);
      i_dbg_req = 1'b0;
      cyc("lock_dbg_rsp", 1'b0, 1'b0, 1'b1);
      i_dbg_lock = 1'b0;
      cyc("unlock2", 1'b0, 1'b0, 1'b1);
      i_cpu_req = 1'b0;
      cyc("arb_again", 1'b0, 1'b0, 1'b0);

      // Reset in the response cycle of a granted read.
      i_cpu_req = 1'b1; i_cpu_addr = 5'h1C;
      cyc("rst_rd", 1'b1, 1'b0, 1'b0);
      i_cpu_req = 1'b0; i_rst = 1'b1;
      cyc("rst_pend", 1'b0, 1'b0, 1'b0);
      i_rst = 1'b0;
      cyc("rst_after", 1'b0, 1'b0, 1'b0);

      // After reset the CPU is preferred again.
      i_cpu_req = 1'b1; i_dbg_req = 1'b1; i_cpu_addr = 5'h00; i_dbg_addr = 5'h04;
      edg = RR ? pref_dbg : 1'b0;
      cyc("rst_pref", !edg, edg, 1'b0);
      i_cpu_req = 1'b0; i_dbg_req = 1'b0;
      cyc("final", 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
